// File: rtl/data_mem_responder.sv
// Data-memory responder for the core's load/store port.
// Word-organised array with byte/halfword/word access, optional wait states,
// and valid/ready handshakes on request and response channels.
module data_mem_responder #(
    parameter int DEPTH       = 1024,
    parameter int ADDR_W      = 32,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic [31:0]       mem [DEPTH];

    logic              lat_we;
    logic [2:0]        lat_f3;
    logic [ADDR_W-1:0] lat_addr;
    logic [31:0]       lat_wdata;

    // Request as seen at commit time: live inputs when committing straight
    // from IDLE (no wait states), otherwise the copy latched at accept.
    logic              c_we;
    logic [2:0]        c_f3;
    logic [ADDR_W-1:0] c_addr;
    logic [31:0]       c_wdata;

    logic              accept, commit, err;
    logic [IDX_W-1:0]  idx;
    logic [1:0]        lane;
    logic [31:0]       word, ld_data, st_word;
    logic [7:0]        sel_b;
    logic [15:0]       sel_h;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign accept    = req_valid && req_ready;
    assign commit    = (state_nxt == RESP) && (state != RESP);

    // Next-state and wait counter
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: if (req_valid) begin
                if (WAIT_CYCLES == 0) begin
                    state_nxt = RESP;
                end else begin
                    state_nxt = WAIT;
                    cnt_nxt   = CNT_INIT;
                end
            end
            WAIT: if (cnt == 4'd0) state_nxt = RESP;
                  else             cnt_nxt   = cnt - 4'd1;
            RESP: if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register and wait counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Capture the request at accept so later input changes are ignored
    always_ff @(posedge clk) begin
        if (accept) begin
            lat_we    <= req_we;
            lat_f3    <= req_funct3;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
        end
    end

    // Decode, error detection, load extraction and store merge
    always_comb begin
        c_we    = (state == IDLE) ? req_we     : lat_we;
        c_f3    = (state == IDLE) ? req_funct3 : lat_f3;
        c_addr  = (state == IDLE) ? req_addr   : lat_addr;
        c_wdata = (state == IDLE) ? req_wdata  : lat_wdata;

        idx   = c_addr[IDX_W+1:2];
        lane  = c_addr[1:0];
        word  = mem[idx];
        sel_b = word[{lane, 3'b000} +: 8];
        sel_h = lane[1] ? word[31:16] : word[15:0];

        err = 1'b0;
        case (c_f3)
            3'b011, 3'b110, 3'b111: err = 1'b1;
            3'b100, 3'b101:         if (c_we) err = 1'b1;
            default: ;
        endcase
        if (c_f3[1:0] == 2'b01 && c_addr[0])          err = 1'b1;
        if (c_f3[1:0] == 2'b10 && c_addr[1:0] != 2'b00) err = 1'b1;
        if ((c_addr >> (IDX_W + 2)) != '0)            err = 1'b1;

        case (c_f3)
            3'b000:  ld_data = {{24{sel_b[7]}}, sel_b};
            3'b001:  ld_data = {{16{sel_h[15]}}, sel_h};
            3'b010:  ld_data = word;
            3'b100:  ld_data = {24'd0, sel_b};
            3'b101:  ld_data = {16'd0, sel_h};
            default: ld_data = 32'd0;
        endcase

        // Unselected lanes keep their old contents
        st_word = word;
        case (c_f3[1:0])
            2'b00:   st_word[{lane, 3'b000} +: 8] = c_wdata[7:0];
            2'b01:   if (lane[1]) st_word[31:16] = c_wdata[15:0];
                     else         st_word[15:0]  = c_wdata[15:0];
            2'b10:   st_word = c_wdata;
            default: ;
        endcase
    end

    // Array write on the edge entering RESP; reset on that edge drops it
    always_ff @(posedge clk) begin
        if (commit && !rst && c_we && !err) mem[idx] <= st_word;
    end

    // Registered response, held stable through RESP
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else if (commit) begin
            rsp_rdata <= (err || c_we) ? 32'd0 : ld_data;
            rsp_err   <= err;
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (no wait states and three wait
// states) checked against a byte-level memory model.
module tb_data_mem_responder;
    localparam int DEPTH = 1024;

    logic             clk = 1'b0;
    logic [1:0]       rst, req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
    logic [1:0][2:0]  req_funct3;
    logic [1:0][31:0] req_addr, req_wdata, rsp_rdata;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem_m [2][16];
    logic [32:0] exp_v [2];
    bit          exp_on [2];

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(DEPTH), .ADDR_W(32), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_funct3(req_funct3[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

    data_mem_responder #(.DEPTH(DEPTH), .ADDR_W(32), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_funct3(req_funct3[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

    function automatic int wc(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    // Reference: returns {err, rdata} and applies any store to the model array.
    // Only addresses 0..63 or >= 4*DEPTH are ever issued.
    function automatic logic [32:0] model(input int d, input bit we, input bit [2:0] f3,
                                          input logic [31:0] a, input logic [31:0] wd);
        int sz, lane;
        logic [31:0] w;
        longint v;
        sz = 1 << f3[1:0];
        if (f3 inside {3'b011, 3'b110, 3'b111} || (we && f3[2]) ||
            (a % sz) != 0 || a >= 4 * DEPTH)
            return {1'b1, 32'h0};
        lane = int'(a[1:0]);
        w = mem_m[d][a[5:2]];
        if (we) begin
            for (int i = 0; i < sz; i++) w[8*(lane+i) +: 8] = wd[8*i +: 8];
            mem_m[d][a[5:2]] = w;
            return {1'b0, 32'h0};
        end
        v = 0;
        for (int i = 0; i < sz; i++) v = v | (longint'(w[8*(lane+i) +: 8]) << (8*i));
        if (!f3[2] && sz < 4 && v[8*sz-1]) v = v - (longint'(1) << (8*sz));
        return {1'b0, v[31:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [32:0] got, input logic [32:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    // Junk on the request inputs while the responder is busy
    task automatic garble(input int d);
        req_valid[d]  = 1'($urandom_range(0, 1));
        req_we[d]     = 1'($urandom_range(0, 1));
        req_funct3[d] = 3'($urandom_range(0, 7));
        req_addr[d]   = $urandom;
        req_wdata[d]  = $urandom;
    endtask

    // One full transaction: accept, latency, hold, handshake
    task automatic issue(input int d, input bit we, input bit [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int hold, output logic [32:0] e);
        int n;
        bit rr_bad;
        e = model(d, we, f3, a, wd);
        chk("req_ready_idle", {32'd0, req_ready[d]}, 33'd1);
        req_valid[d] = 1'b1; req_we[d] = we; req_funct3[d] = f3;
        req_addr[d] = a; req_wdata[d] = wd;
        exp_v[d] = e; exp_on[d] = 1'b1;
        tick();
        n = 0; rr_bad = 1'b0;
        while (rsp_valid[d] !== 1'b1 && n < 40) begin
            if (req_ready[d] !== 1'b0) rr_bad = 1'b1;
            garble(d); tick(); n++;
        end
        chk($sformatf("latency%0d", d), 33'(n), 33'(wc(d)));
        for (int i = 0; i < hold; i++) begin
            if (req_ready[d] !== 1'b0) rr_bad = 1'b1;
            garble(d); tick();
        end
        chk("req_ready_busy", {32'd0, rr_bad}, 33'd0);
        req_valid[d] = 1'b0; rsp_ready[d] = 1'b1;
        tick();
        rsp_ready[d] = 1'b0; exp_on[d] = 1'b0;
        chk("after_handshake", {31'd0, rsp_valid[d], req_ready[d]}, 33'b01);
    endtask

    // Response check on every cycle the response is presented
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rsp_valid[d] === 1'b1) begin
                checks++;
                if (!exp_on[d] || {rsp_err[d], rsp_rdata[d]} !== exp_v[d]) begin
                    errors++;
                    $display("FAIL rsp%0d got err=%b rdata=%h want expected=%b err/rdata=%h",
                             d, rsp_err[d], rsp_rdata[d], exp_on[d], exp_v[d]);
                end
            end
        end
    end

    initial begin
        logic [32:0] e;
        rst = 2'b11; req_valid = '0; req_we = '0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0; rsp_ready = '0;
        exp_on[0] = 1'b0; exp_on[1] = 1'b0;
        repeat (3) tick();
        rst = 2'b00;
        for (int d = 0; d < 2; d++)
            chk($sformatf("reset_state%0d", d),
                {rsp_valid[d], req_ready[d], rsp_err[d], rsp_rdata[d][29:0]},
                {1'b0, 1'b1, 1'b0, 30'd0});

        // Give every modelled word a known value
        for (int d = 0; d < 2; d++)
            for (int w = 0; w < 16; w++) issue(d, 1'b1, 3'b010, 32'(w * 4), $urandom, 0, e);

        // No wait states: basic store/load and sub-word access
        issue(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, e);
        issue(0, 1'b0, 3'b010, 32'h10, 32'h0, 0, e);  chk("lw_10", e, {1'b0, 32'hDEADBEEF});
        issue(0, 1'b1, 3'b000, 32'h12, 32'h80, 0, e);
        issue(0, 1'b0, 3'b000, 32'h12, 32'h0, 0, e);  chk("lb_12", e, {1'b0, 32'hFFFFFF80});
        issue(0, 1'b0, 3'b100, 32'h12, 32'h0, 1, e);  chk("lbu_12", e, {1'b0, 32'h00000080});
        issue(0, 1'b0, 3'b010, 32'h10, 32'h0, 0, e);  chk("lw_10b", e, {1'b0, 32'hDE80BEEF});

        // Error cases
        issue(0, 1'b0, 3'b001, 32'h13, 32'h0, 0, e);  chk("lh_mis", e, {1'b1, 32'h0});
        issue(0, 1'b1, 3'b010, 32'h11, 32'h5555, 0, e); chk("sw_mis", e, {1'b1, 32'h0});
        issue(0, 1'b0, 3'b010, 32'h10, 32'h0, 0, e);  chk("lw_unch", e, {1'b0, 32'hDE80BEEF});
        issue(0, 1'b0, 3'b010, 32'h1000, 32'h0, 0, e); chk("lw_oor", e, {1'b1, 32'h0});
        issue(0, 1'b0, 3'b011, 32'h10, 32'h0, 0, e);  chk("ld_f3_011", e, {1'b1, 32'h0});
        issue(0, 1'b1, 3'b100, 32'h10, 32'h0, 0, e);  chk("st_f3_100", e, {1'b1, 32'h0});

        // Halfword store onto a zeroed word
        issue(0, 1'b1, 3'b010, 32'h20, 32'h0, 0, e);
        issue(0, 1'b1, 3'b001, 32'h22, 32'hA5A5, 0, e);
        issue(0, 1'b0, 3'b101, 32'h22, 32'h0, 0, e);  chk("lhu_22", e, {1'b0, 32'h0000A5A5});
        issue(0, 1'b0, 3'b001, 32'h22, 32'h0, 0, e);  chk("lh_22", e, {1'b0, 32'hFFFFA5A5});
        issue(0, 1'b0, 3'b010, 32'h20, 32'h0, 0, e);  chk("lw_20", e, {1'b0, 32'hA5A50000});

        // Three wait states with a stalled consumer
        issue(1, 1'b1, 3'b010, 32'h20, 32'hCAFEF00D, 0, e);
        issue(1, 1'b0, 3'b010, 32'h20, 32'h0, 5, e);  chk("lw_w3", e, {1'b0, 32'hCAFEF00D});

        // Reset during the second wait cycle drops the pending store
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_funct3[1] = 3'b010;
        req_addr[1] = 32'h20; req_wdata[1] = 32'h12345678;
        tick();
        req_valid[1] = 1'b0;
        tick();
        rst[1] = 1'b1;
        tick();
        rst[1] = 1'b0;
        chk("post_rst", {rsp_valid[1], req_ready[1], rsp_err[1], rsp_rdata[1][29:0]},
            {1'b0, 1'b1, 1'b0, 30'd0});
        repeat (5) tick();
        issue(1, 1'b0, 3'b010, 32'h20, 32'h0, 0, e);  chk("lw_after_rst", e, {1'b0, 32'hCAFEF00D});

        // Randomised traffic on both instances
        for (int k = 0; k < 120; k++) begin
            int d;
            logic [31:0] a;
            d = k % 2;
            if ($urandom_range(0, 4) == 0) a = 32'h1000 | $urandom;
            else                           a = 32'($urandom_range(0, 63));
            issue(d, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
                  $urandom_range(0, 3), e);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
